// File: rtl/operand_gen_unit_if.sv
// ============================================================================
// Module      : operand_gen_unit_if
// Description : Avalon-MM slave bus bundle for the operand generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface operand_gen_unit_if;
    logic [2:0]  address;
    logic [31:0] writedata;
    logic        write;
    logic        read;
    logic [31:0] readdata;

    modport slave (
        input  address,
        input  writedata,
        input  write,
        input  read,
        output readdata
    );

    modport master (
        output address,
        output writedata,
        output write,
        output read,
        input  readdata
    );
endinterface

`default_nettype wire

// File: rtl/operand_gen_unit.sv
// ============================================================================
// Module      : operand_gen_unit
// Description : Fills operand A/B RAMs with two LFSR streams on command.
//               Optional checksum register enabled by OPERAND_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_gen_unit #(
    parameter int unsigned ID = 2
) (
    input  wire logic          avalon_clock,
    input  wire logic          resetn,
    operand_gen_unit_if.slave  avs,
    output logic [10:0]        ram_addr,
    output logic [31:0]        ram_data_a,
    output logic [31:0]        ram_data_b,
    output logic               ram_we,
    output logic               busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] base_q;
    logic [11:0] count_q;
    logic [31:0] seed_a_q, seed_b_q;
    logic [10:0] addr_q;
    logic [11:0] remaining_q;
    logic [31:0] lfsr_a_q, lfsr_b_q;
    logic        ram_we_q;
    logic [10:0] ram_addr_q;
    logic [31:0] ram_data_a_q, ram_data_b_q;
    logic [31:0] readdata_q;
    logic [31:0] csum_rd;

    logic        ctrl_wr;
    logic        cfg_wr;
    logic        load;
    logic        step;
    logic [31:0] rd_mux;

    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        return {1'b0, x[31:1]} ^ (x[0] ? 32'hA300_0000 : 32'h0);
    endfunction

    assign ctrl_wr = avs.write && (avs.address == 3'd0);
    assign cfg_wr  = avs.write && (state_q != S_FILL);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                // clear takes priority over start when both bits are set
                if (ctrl_wr && avs.writedata[1]) begin
                    state_d = S_IDLE;
                end else if (ctrl_wr && avs.writedata[0]) begin
                    load    = 1'b1;
                    state_d = (count_q == 12'd0) ? S_DONE : S_FILL;
                end
            end
            S_FILL: begin
                step = 1'b1;
                if (remaining_q == 12'd1) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge avalon_clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge avalon_clock or negedge resetn) begin
        if (!resetn) begin
            base_q       <= '0;
            count_q      <= '0;
            seed_a_q     <= '0;
            seed_b_q     <= '0;
            addr_q       <= '0;
            remaining_q  <= '0;
            lfsr_a_q     <= '0;
            lfsr_b_q     <= '0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_data_a_q <= '0;
            ram_data_b_q <= '0;
        end else begin
            if (cfg_wr) begin
                case (avs.address)
                    3'd1:    base_q   <= avs.writedata[10:0];
                    3'd2:    count_q  <= avs.writedata[11:0];
                    3'd3:    seed_a_q <= avs.writedata;
                    3'd4:    seed_b_q <= avs.writedata;
                    default: ;
                endcase
            end

            ram_we_q <= step;
            if (load) begin
                addr_q      <= base_q;
                remaining_q <= (count_q > 12'd2048) ? 12'd2048 : count_q;
                // an all-zero seed would lock the LFSR, so substitute 1
                lfsr_a_q    <= (seed_a_q == 32'd0) ? 32'd1 : seed_a_q;
                lfsr_b_q    <= (seed_b_q == 32'd0) ? 32'd1 : seed_b_q;
            end else if (step) begin
                ram_addr_q   <= addr_q;
                ram_data_a_q <= lfsr_a_q;
                ram_data_b_q <= lfsr_b_q;
                addr_q       <= addr_q + 11'd1;
                remaining_q  <= remaining_q - 12'd1;
                lfsr_a_q     <= lfsr_next(lfsr_a_q);
                lfsr_b_q     <= lfsr_next(lfsr_b_q);
            end
        end
    end

`ifdef OPERAND_CHECKSUM_EN
    logic [31:0] checksum_q;

    always_ff @(posedge avalon_clock or negedge resetn) begin
        if (!resetn) begin
            checksum_q <= '0;
        end else if (load) begin
            checksum_q <= '0;
        end else if (step) begin
            checksum_q <= checksum_q ^ lfsr_a_q ^ lfsr_b_q;
        end
    end

    assign csum_rd = checksum_q;
`else
    assign csum_rd = 32'd0;
`endif

    always_comb begin
        rd_mux = 32'd0;
        case (avs.address)
            3'd0:    rd_mux = {30'd0, (state_q == S_DONE), (state_q == S_FILL)};
            3'd1:    rd_mux = {21'd0, base_q};
            3'd2:    rd_mux = {20'd0, count_q};
            3'd3:    rd_mux = seed_a_q;
            3'd4:    rd_mux = seed_b_q;
            3'd5:    rd_mux = csum_rd;
            3'd6:    rd_mux = ID;
            default: rd_mux = 32'd0;
        endcase
    end

    // sampling the pre-edge register values gives read-before-write ordering
    always_ff @(posedge avalon_clock or negedge resetn) begin
        if (!resetn) begin
            readdata_q <= '0;
        end else if (avs.read) begin
            readdata_q <= rd_mux;
        end
    end

    assign avs.readdata = readdata_q;
    assign ram_we       = ram_we_q;
    assign ram_addr     = ram_addr_q;
    assign ram_data_a   = ram_data_a_q;
    assign ram_data_b   = ram_data_b_q;
    assign busy         = (state_q == S_FILL);

endmodule

`default_nettype wire

// File: tb/tb_operand_gen_unit.sv
// ============================================================================
// Module      : tb_operand_gen_unit
// Description : Directed self-checking bench for operand_gen_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_operand_gen_unit;

    typedef struct {
        logic [10:0] a;
        logic [31:0] da;
        logic [31:0] db;
    } wr_t;

    logic        clk;
    logic        resetn;
    logic [10:0] ram_addr;
    logic [31:0] ram_data_a;
    logic [31:0] ram_data_b;
    logic        ram_we;
    logic        busy;

    int          total;
    int          fails;
    int          busy_cnt;
    wr_t         wq[$];
    logic [31:0] rd;

    operand_gen_unit_if bus ();

    operand_gen_unit #(.ID(2)) dut (
        .avalon_clock (clk),
        .resetn       (resetn),
        .avs          (bus),
        .ram_addr     (ram_addr),
        .ram_data_a   (ram_data_a),
        .ram_data_b   (ram_data_b),
        .ram_we       (ram_we),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ram_we === 1'b1) wq.push_back('{a: ram_addr, da: ram_data_a, db: ram_data_b});
        if (busy === 1'b1) busy_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address   = a;
        bus.writedata = d;
        bus.write     = 1'b1;
        @(negedge clk);
        bus.write     = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.address = a;
        bus.read    = 1'b1;
        @(negedge clk);
        bus.read    = 1'b0;
        d = bus.readdata;
    endtask

    task automatic wait_done(input int max);
        int n = 0;
        while (busy !== 1'b0 && n < max) begin
            @(negedge clk);
            n++;
        end
        check("run_timeout", (n < max) ? 32'd1 : 32'd0, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic setup_run(input logic [31:0] base, input logic [31:0] cnt,
                             input logic [31:0] sa, input logic [31:0] sb);
        bus_write(3'd1, base);
        bus_write(3'd2, cnt);
        bus_write(3'd3, sa);
        bus_write(3'd4, sb);
        wq.delete();
        busy_cnt = 0;
        bus_write(3'd0, 32'd1);
    endtask

    initial begin
        int n;
        int sz;
        total         = 0;
        fails         = 0;
        busy_cnt      = 0;
        resetn        = 1'b0;
        bus.address   = '0;
        bus.writedata = '0;
        bus.write     = 1'b0;
        bus.read      = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;

        // reset state
        check("rst_ram_we", {31'd0, ram_we}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ram_addr", {21'd0, ram_addr}, 32'd0);
        check("rst_ram_data_a", ram_data_a, 32'd0);
        check("rst_readdata", bus.readdata, 32'd0);
        bus_read(3'd0, rd); check("rst_status", rd, 32'd0);
        bus_read(3'd1, rd); check("rst_base", rd, 32'd0);
        bus_read(3'd6, rd); check("id_reg", rd, 32'd2);
        bus_read(3'd7, rd); check("reg7", rd, 32'd0);

        // basic run: 4 words from address 0
        setup_run(32'd0, 32'd4, 32'd1, 32'd2);
        wait_done(50);
        check("r1_nwrites", wq.size(), 32'd4);
        if (wq.size() == 4) begin
            check("r1_addr0", {21'd0, wq[0].a}, 32'd0);
            check("r1_addr3", {21'd0, wq[3].a}, 32'd3);
            check("r1_a0", wq[0].da, 32'h0000_0001);
            check("r1_a1", wq[1].da, 32'hA300_0000);
            check("r1_a2", wq[2].da, 32'h5180_0000);
            check("r1_a3", wq[3].da, 32'h28C0_0000);
            check("r1_b0", wq[0].db, 32'h0000_0002);
            check("r1_b1", wq[1].db, 32'h0000_0001);
            check("r1_b2", wq[2].db, 32'hA300_0000);
        end
        check("r1_busy_cycles", busy_cnt, 32'd4);
        bus_read(3'd0, rd); check("r1_status_done", rd, 32'd2);

        // address wrap at 2047
        setup_run(32'd2046, 32'd3, 32'd5, 32'd9);
        wait_done(50);
        check("wrap_nwrites", wq.size(), 32'd3);
        if (wq.size() == 3) begin
            check("wrap_addr0", {21'd0, wq[0].a}, 32'd2046);
            check("wrap_addr1", {21'd0, wq[1].a}, 32'd2047);
            check("wrap_addr2", {21'd0, wq[2].a}, 32'd0);
        end

        // zero count: straight to DONE, no writes
        setup_run(32'd7, 32'd0, 32'd1, 32'd1);
        repeat (6) @(negedge clk);
        check("zero_nwrites", wq.size(), 32'd0);
        check("zero_busy_cycles", busy_cnt, 32'd0);
        bus_read(3'd0, rd); check("zero_status", rd, 32'd2);

        // clear returns to IDLE
        bus_write(3'd0, 32'd2);
        bus_read(3'd0, rd); check("clear_status", rd, 32'd0);

        // zero seed substitution and reset mid-fill
        setup_run(32'd0, 32'd100, 32'd0, 32'd3);
        n = 0;
        while (wq.size() < 50 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("fill50_timeout", (n < 200) ? 32'd1 : 32'd0, 32'd1);
        resetn = 1'b0;
        #1;
        check("async_rst_ram_we", {31'd0, ram_we}, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        if (wq.size() > 0) check("zero_seed_a0", wq[0].da, 32'h0000_0001);
        @(negedge clk);
        resetn = 1'b1;
        sz = wq.size();
        repeat (5) @(negedge clk);
        check("post_rst_no_writes", wq.size(), sz);
        bus_read(3'd0, rd); check("post_rst_status", rd, 32'd0);
        bus_read(3'd2, rd); check("post_rst_count", rd, 32'd0);

        // start and config writes ignored while filling
        setup_run(32'd10, 32'd6, 32'd1, 32'd2);
        bus_write(3'd1, 32'd5);
        bus_write(3'd0, 32'd1);
        wait_done(50);
        check("ign_nwrites", wq.size(), 32'd6);
        if (wq.size() == 6) begin
            check("ign_addr0", {21'd0, wq[0].a}, 32'd10);
            check("ign_addr5", {21'd0, wq[5].a}, 32'd15);
        end
        bus_read(3'd1, rd); check("ign_base_kept", rd, 32'd10);
        bus_write(3'd0, 32'd2);
        bus_read(3'd0, rd); check("ign_clear_status", rd, 32'd0);

        // same-cycle read and write of one register returns the old value
        @(negedge clk);
        bus.address   = 3'd1;
        bus.writedata = 32'd77;
        bus.write     = 1'b1;
        bus.read      = 1'b1;
        @(negedge clk);
        bus.write = 1'b0;
        bus.read  = 1'b0;
        check("rw_old_value", bus.readdata, 32'd10);
        bus_read(3'd1, rd); check("rw_new_value", rd, 32'd77);

        // clear outranks start when both bits set
        bus_write(3'd2, 32'd3);
        wq.delete();
        bus_write(3'd0, 32'd3);
        repeat (4) @(negedge clk);
        check("clr_prio_nwrites", wq.size(), 32'd0);
        bus_read(3'd0, rd); check("clr_prio_status", rd, 32'd0);

        // count above 2048 is clamped
        setup_run(32'd0, 32'd4095, 32'd1, 32'd2);
        wait_done(3000);
        check("clamp_nwrites", wq.size(), 32'd2048);
        if (wq.size() == 2048) check("clamp_last_addr", {21'd0, wq[2047].a}, 32'd2047);

        // checksum register
        setup_run(32'd0, 32'd2, 32'd1, 32'd2);
        wait_done(50);
`ifdef OPERAND_CHECKSUM_EN
        bus_read(3'd5, rd); check("checksum", rd, 32'hA300_0002);
`else
        bus_read(3'd5, rd); check("checksum_absent", rd, 32'd0);
`endif

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/operand_gen_unit.md
OPERAND_GEN_UNIT -- requirements
Module: operand_gen_unit

Interface
REQ-001 SHALL have parameter: ID, default 2, value returned at register 6.
REQ-002 SHALL have port: avalon_clock  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port: resetn  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: address in 3 (register select); writedata in 32; write in 1; read in 1; readdata out 32 (Avalon-MM slave).
REQ-005 SHALL have ports: ram_addr out 11; ram_data_a out 32; ram_data_b out 32; ram_we out 1; these drive the write side of the operand A/B RAMs.
REQ-006 SHALL have port: busy  out  1  high while in FILL.

Function
REQ-007 SHALL implement a register map:
- 0 ctrl/status: write bit0=1 start, bit1=1 clear; read {30'b0, done, busy}.
- 1 base address [10:0].
- 2 count [11:0].
- 3 seed_a.
- 4 seed_b.
- 5 checksum (see Configuration).
- 6 ID.
- 7 reads 0.
REQ-008 SHALL register readdata, updating it on the edge after read is sampled; unmapped addresses return 0.
REQ-009 SHALL implement an FSM with states IDLE, FILL, DONE.
REQ-010 SHALL, on start in IDLE or DONE, load addr=base, remaining=min(count,2048), lfsr_a=seed_a, lfsr_b=seed_b (zero seed replaced by 32'h1), then enter FILL; count=0 goes directly to DONE with no write.
REQ-011 SHALL, in FILL, each cycle drive ram_we=1, ram_addr=addr, ram_data_a=lfsr_a, ram_data_b=lfsr_b, all registered; first ram_we high one cycle after the start write is sampled.
REQ-012 SHALL advance each LFSR per written word: shift right by 1; if the old bit0 was 1, XOR with 32'hA3000000.
REQ-013 SHALL increment addr modulo 2048 (2047 wraps to 0).
REQ-014 SHALL enter DONE after the write with remaining=1, with ram_we low from the next cycle; exactly min(count,2048) writes per run.
REQ-015 SHALL ignore start and writes to registers 1–4 while in FILL.
REQ-016 SHALL hold done=1 in DONE until clear (returns to IDLE) or start (new run); clear outranks start when both bits are set.
REQ-017 SHALL drive busy=1 exactly in FILL.
REQ-018 SHALL give simultaneous read and write to the same register the old value.

Reset
REQ-019 SHALL, on resetn low, clear immediately to: state IDLE; ram_we=0; busy=0; done=0; ram_addr=0; ram_data_a/b=0; readdata=0; base, count, seeds=0; checksum=0.
REQ-020 SHALL, on reset during FILL, drop ram_we asynchronously and leave no partial-run state after release.

Configuration
REQ-021 SHALL, with macro OPERAND_CHECKSUM_EN defined, XOR each written {ram_data_a ^ ram_data_b} into a 32-bit checksum cleared on start, readable at register 5.
REQ-022 SHALL, without OPERAND_CHECKSUM_EN, include no checksum logic, with register 5 reading 0.

Verification
REQ-023 SHALL cover: base=0, count=4, seed_a=1, seed_b=2, start -> 4 writes at addr 0..3; A=1,0xA3000000,0x51800000,0x28C00000; busy 4 cycles; then done=1.
REQ-024 SHALL cover: base=2046, count=3 -> writes to 2046, 2047, 0; no write to 1.
REQ-025 SHALL cover: count=0, start -> no ram_we pulse; status reads 2'b10.
REQ-026 SHALL cover: count=100, seed_a=0 -> first A word 0x1; reset asserted at write 50 -> ram_we low immediately; status 0 after release.
REQ-027 SHALL cover: during FILL, write base=5 and start -> ignored; run completes at the original addresses; clear then reads status 0.
REQ-028 SHALL cover, with OPERAND_CHECKSUM_EN: count=2, seeds 1 and 2 -> register 5 = (1^2)^(0xA3000000^1) = 0xA3000002.
